// File: rtl/ext_tid_alloc_if.sv
// ---------------------------------------------------------------------------
// ext_tid_alloc_if
//   Groups the allocate and release paths of the external TID allocator.
//
//   Signals (named from the allocator's point of view):
//     alloc_req_i   requester -> allocator  asks for a new external TID
//     alloc_gnt_o   allocator -> requester  a TID is handed out this cycle
//     alloc_tid_o   allocator -> requester  the TID handed out (valid with gnt)
//     rel_valid_i   requester -> allocator  a response came back, free its TID
//     rel_tid_i     requester -> allocator  the TID being freed
//
//   Handshake: an allocation transfers in every cycle where alloc_req_i and
//   alloc_gnt_o are both high at the rising clock edge; alloc_gnt_o is never
//   high without alloc_req_i, and the requester may hold alloc_req_i high for
//   as long as it wants more TIDs. A release has no back-pressure: every cycle
//   with rel_valid_i high at the rising edge is consumed by the allocator.
//
//   Modports: master = requester side, slave = allocator side.
// ---------------------------------------------------------------------------
interface ext_tid_alloc_if #(
    parameter int EXT_TID_WIDTH = 4
);
    logic                     alloc_req_i;
    logic                     alloc_gnt_o;
    logic [EXT_TID_WIDTH-1:0] alloc_tid_o;
    logic                     rel_valid_i;
    logic [EXT_TID_WIDTH-1:0] rel_tid_i;

    modport master (
        output alloc_req_i,
        output rel_valid_i,
        output rel_tid_i,
        input  alloc_gnt_o,
        input  alloc_tid_o
    );

    modport slave (
        input  alloc_req_i,
        input  rel_valid_i,
        input  rel_tid_i,
        output alloc_gnt_o,
        output alloc_tid_o
    );
endinterface

// File: rtl/ext_tid_alloc.sv
// ---------------------------------------------------------------------------
// ext_tid_alloc
//   Pool of 2**EXT_TID_WIDTH external transaction IDs. A busy bitmap tracks
//   which IDs are outstanding; the lowest free ID is offered combinationally
//   and becomes busy on the granting edge. Returned responses free their ID,
//   which becomes allocatable from the following cycle.
//
//   Ports:
//     clk_i          clock, rising edge
//     rst_ni         asynchronous active-low reset
//     bus            ext_tid_alloc_if.slave: alloc req/gnt/tid, release valid/tid
//     drain_i        block new grants; releases keep being processed
//     err_clr_i      clear the sticky illegal-release flag
//     full_o         every ID is outstanding
//     idle_o         no ID is outstanding
//     outstanding_o  number of outstanding IDs (0..2**EXT_TID_WIDTH)
//     err_o          sticky: a release named an ID that was not outstanding
// ---------------------------------------------------------------------------
module ext_tid_alloc #(
    parameter int EXT_TID_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ext_tid_alloc_if.slave         bus,
    input  logic                   drain_i,
    input  logic                   err_clr_i,
    output logic                   full_o,
    output logic                   idle_o,
    output logic [EXT_TID_WIDTH:0] outstanding_o,
    output logic                   err_o
);
    localparam int NUM_TID = 2**EXT_TID_WIDTH;
    localparam logic [EXT_TID_WIDTH:0] NUM_TID_CNT = (EXT_TID_WIDTH+1)'(NUM_TID);
    localparam logic [EXT_TID_WIDTH:0] CNT_ONE     = (EXT_TID_WIDTH+1)'(1);

    logic [NUM_TID-1:0]       busy_q, busy_d;
    logic [EXT_TID_WIDTH:0]   cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [EXT_TID_WIDTH-1:0] free_tid;
    logic                     full;
    logic                     gnt;
    logic                     rel_legal;
    logic                     rel_illegal;

    // Lowest-index free ID. Scanning downward lets the last hit win, which is
    // the lowest index; with no free ID the default 0 is left in place.
    always_comb begin
        free_tid = '0;
        for (int i = NUM_TID - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_tid = EXT_TID_WIDTH'(i);
            end
        end
    end

    assign full = (cnt_q == NUM_TID_CNT);

    // rst_ni gates the grant directly: while reset is held the registered
    // full flag reads 0, so nothing else would stop a grant then.
    assign gnt = rst_ni & bus.alloc_req_i & ~full & ~drain_i;

    // Legality uses the registered bitmap only, so releasing the ID that is
    // being granted in the same cycle is seen as freeing a free ID.
    assign rel_legal   = bus.rel_valid_i &  busy_q[bus.rel_tid_i];
    assign rel_illegal = bus.rel_valid_i & ~busy_q[bus.rel_tid_i];

    always_comb begin
        busy_d = busy_q;
        if (gnt) begin
            busy_d[free_tid] = 1'b1;
        end
        if (rel_legal) begin
            busy_d[bus.rel_tid_i] = 1'b0;
        end

        cnt_d = cnt_q;
        case ({gnt, rel_legal})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        // A new error wins over a clear in the same cycle.
        err_d = err_q;
        if (rel_illegal) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.alloc_gnt_o = gnt;
    assign bus.alloc_tid_o = free_tid;
    assign full_o          = full;
    assign idle_o          = (cnt_q == '0);
    assign outstanding_o   = cnt_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_ext_tid_alloc.sv
// ---------------------------------------------------------------------------
// tb_ext_tid_alloc
//   Drives directed scenarios and random traffic into ext_tid_alloc. The
//   driver keeps a reference pool (an array of busy flags plus a sticky error
//   bit) and, for every driven cycle, pushes the expected outputs onto exp_q.
//   A monitor on the falling clock edge pops one entry per driven cycle and
//   compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_ext_tid_alloc;
    localparam int W   = 4;
    localparam int NUM = 2**W;
    // Expected entry layout: {gnt, tid[W-1:0], full, idle, cnt[W:0], err}
    localparam int EW  = 2*W + 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_ni;
    logic drain;
    logic err_clr;
    logic full;
    logic idle;
    logic err;
    logic [W:0] outst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ext_tid_alloc_if #(.EXT_TID_WIDTH(W)) bus ();

    ext_tid_alloc #(.EXT_TID_WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .drain_i       (drain),
        .err_clr_i     (err_clr),
        .full_o        (full),
        .idle_o        (idle),
        .outstanding_o (outst),
        .err_o         (err)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference pool
    bit m_busy[NUM];
    bit m_err;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NUM; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < NUM; i++) begin
            if (!m_busy[i]) return i;
        end
        return 0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NUM; i++) m_busy[i] = 1'b0;
        m_err = 1'b0;
    endfunction

    // ---------------- driver ----------------
    // One clock cycle of stimulus. Inputs change 1 ns after the rising edge;
    // the expected outputs for this cycle are queued, then the reference pool
    // is advanced to what the next rising edge must leave behind.
    task automatic cycle(input bit req, input bit rv, input int rt, input bit dr, input bit clr);
        int         cnt;
        int         tid_e;
        bit         full_e;
        bit         gnt_e;
        bit         legal;
        bit         illegal;
        logic [W-1:0] tid_v;
        logic [W:0]   cnt_v;
        @(posedge clk);
        #1;
        bus.alloc_req_i = req;
        bus.rel_valid_i = rv;
        bus.rel_tid_i   = rt[W-1:0];
        drain           = dr;
        err_clr         = clr;
        #1;
        cnt    = m_count();
        full_e = (cnt == NUM);
        gnt_e  = req && !dr && !full_e;
        tid_e  = full_e ? 0 : m_lowest_free();
        tid_v  = tid_e[W-1:0];
        cnt_v  = cnt[W:0];
        exp_q.push_back({gnt_e, tid_v, full_e, (cnt == 0), cnt_v, m_err});
        // Legality is judged on the pool as it stood before this cycle.
        legal   = rv &&  m_busy[rt];
        illegal = rv && !m_busy[rt];
        if (gnt_e) m_busy[tid_e] = 1'b1;
        if (legal) m_busy[rt]    = 1'b0;
        if (illegal)  m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic random_cycle();
        bit req;
        bit rv;
        bit dr;
        bit clr;
        int rt;
        int start;
        req   = ($urandom_range(0, 3) != 0);
        rv    = ($urandom_range(0, 1) == 1);
        dr    = ($urandom_range(0, 9) == 0);
        clr   = ($urandom_range(0, 7) == 0);
        rt    = $urandom_range(0, NUM - 1);
        // Mostly release something outstanding; occasionally a random ID so
        // illegal releases also appear.
        if ($urandom_range(0, 7) != 0) begin
            start = $urandom_range(0, NUM - 1);
            for (int k = 0; k < NUM; k++) begin
                if (m_busy[(start + k) % NUM]) begin
                    rt = (start + k) % NUM;
                    break;
                end
            end
        end
        cycle(req, rv, rt, dr, clr);
    endtask

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_ni          = 1'b0;
        bus.alloc_req_i = 1'b1;
        bus.rel_valid_i = 1'b0;
        drain           = 1'b0;
        err_clr         = 1'b0;
        #1;
        check("rst_async_gnt",   int'(bus.alloc_gnt_o), 0);
        check("rst_async_full",  int'(full),  0);
        check("rst_async_idle",  int'(idle),  1);
        check("rst_async_outst", int'(outst), 0);
        check("rst_async_err",   int'(err),   0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_gnt",  int'(bus.alloc_gnt_o), 0);
        check("rst_held_idle", int'(idle), 1);
        bus.alloc_req_i = 1'b0;
        m_reset();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt",   int'(bus.alloc_gnt_o), int'(e[2*W+4]));
            check("tid",   int'(bus.alloc_tid_o), int'(e[2*W+3:W+4]));
            check("full",  int'(full),            int'(e[W+3]));
            check("idle",  int'(idle),            int'(e[W+2]));
            check("outst", int'(outst),           int'(e[W+1:1]));
            check("err",   int'(err),             int'(e[0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_ni          = 1'b0;
        bus.alloc_req_i = 1'b0;
        bus.rel_valid_i = 1'b0;
        bus.rel_tid_i   = '0;
        drain           = 1'b0;
        err_clr         = 1'b0;
        m_reset();
        #1;
        check("init_idle",  int'(idle),  1);
        check("init_full",  int'(full),  0);
        check("init_outst", int'(outst), 0);
        check("init_err",   int'(err),   0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Three back-to-back requests after reset: IDs 0, 1, 2.
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("first_tid", int'(bus.alloc_tid_o), 0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("third_tid", int'(bus.alloc_tid_o), 2);
        idle_cycle();
        check("three_outst", int'(outst), 3);
        check("three_idle",  int'(idle),  0);

        // Fill the pool, then one request too many.
        repeat (NUM - 3) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("full_set",   int'(full),              1);
        check("full_nognt", int'(bus.alloc_gnt_o),   0);
        check("full_outst", int'(outst),             NUM);
        // Release 5 while requesting: no grant in the same cycle.
        cycle(1'b1, 1'b1, 5, 1'b0, 1'b0);
        check("rel_no_bypass", int'(bus.alloc_gnt_o), 0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("regrant_gnt", int'(bus.alloc_gnt_o), 1);
        check("regrant_tid", int'(bus.alloc_tid_o), 5);
        idle_cycle();
        check("refull", int'(full), 1);
        for (int i = 0; i < NUM; i++) cycle(1'b0, 1'b1, i, 1'b0, 1'b0);
        idle_cycle();
        check("drained_idle", int'(idle), 1);

        // IDs 0..3 busy, release 1 while requesting: grant 4, count holds.
        repeat (4) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1, 1'b0, 1'b0);
        check("swap_tid", int'(bus.alloc_tid_o), 4);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("swap_outst", int'(outst), 4);
        check("swap_next",  int'(bus.alloc_tid_o), 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, i, 1'b0, 1'b0);

        // Illegal release of a free ID, then clear.
        cycle(1'b0, 1'b1, 9, 1'b0, 1'b0);
        idle_cycle();
        check("illegal_err",   int'(err),   1);
        check("illegal_outst", int'(outst), 0);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle_cycle();
        check("err_cleared", int'(err), 0);
        // Error and clear in the same cycle: set wins.
        cycle(1'b0, 1'b1, 9, 1'b0, 1'b1);
        idle_cycle();
        check("set_over_clr", int'(err), 1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        // Releasing the ID being granted: error, grant still completes.
        cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("samecyc_gnt", int'(bus.alloc_gnt_o), 1);
        idle_cycle();
        check("samecyc_outst", int'(outst), 1);
        check("samecyc_err",   int'(err),   1);
        cycle(1'b0, 1'b1, 0, 1'b0, 1'b1);
        idle_cycle();
        check("samecyc_clr", int'(err), 0);

        // Drain with two outstanding.
        repeat (2) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        check("drain_nognt", int'(bus.alloc_gnt_o), 0);
        cycle(1'b1, 1'b1, 0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b1, 1'b0);
        check("drain_idle", int'(idle), 1);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("undrain_gnt", int'(bus.alloc_gnt_o), 1);
        check("undrain_tid", int'(bus.alloc_tid_o), 0);
        cycle(1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Seven outstanding, then asynchronous reset.
        repeat (7) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle_cycle();
        check("pre_rst_outst", int'(outst), 7);
        do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("post_rst_gnt", int'(bus.alloc_gnt_o), 1);
        check("post_rst_tid", int'(bus.alloc_tid_o), 0);

        // Random traffic, with one reset in the middle.
        repeat (400) random_cycle();
        do_reset();
        repeat (400) random_cycle();
        idle_cycle();

        @(negedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ext_tid_alloc.md
EXT_TID_ALLOC -- requirements
Module: ext_tid_alloc

Interface
REQ-001 SHALL have parameter EXT_TID_WIDTH, default 4, width of the external transaction ID.
REQ-002 SHALL derive localparam NUM_TID = 2**EXT_TID_WIDTH, the number of IDs in the pool.
REQ-003 SHALL have port clk_i, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port alloc_req_i, input, 1, request for a new external TID.
REQ-006 SHALL have port alloc_gnt_o, output, 1, allocation granted this cycle.
REQ-007 SHALL have port alloc_tid_o, output, EXT_TID_WIDTH, granted TID, meaningful only when alloc_gnt_o=1.
REQ-008 SHALL have port rel_valid_i, input, 1, a response returned and its TID is to be freed.
REQ-009 SHALL have port rel_tid_i, input, EXT_TID_WIDTH, TID being freed.
REQ-010 SHALL have port drain_i, input, 1, block new allocations; releases continue.
REQ-011 SHALL have port err_clr_i, input, 1, clears the sticky error flag.
REQ-012 SHALL have port full_o, output, 1, no free TID.
REQ-013 SHALL have port idle_o, output, 1, no TID outstanding.
REQ-014 SHALL have port outstanding_o, output, EXT_TID_WIDTH+1, count of allocated TIDs.
REQ-015 SHALL have port err_o, output, 1, sticky flag for an illegal release.

Function
REQ-016 SHALL keep a NUM_TID-bit busy bitmap; bit n=1 means TID n is outstanding.
REQ-017 SHALL drive alloc_gnt_o combinationally as alloc_req_i AND NOT full_o AND NOT drain_i.
REQ-018 SHALL drive alloc_tid_o combinationally as the lowest-index free TID; it SHALL be 0 when full.
REQ-019 SHALL, on a clock edge with alloc_gnt_o=1, set the busy bit of alloc_tid_o; the TID is usable downstream in the same cycle (zero latency).
REQ-020 SHALL, on a clock edge with rel_valid_i=1 and busy[rel_tid_i]=1, clear that busy bit.
REQ-021 SHALL make a released TID allocatable from the next cycle only; there is no same-cycle bypass from release to grant.
REQ-022 SHALL, on rel_valid_i=1 with busy[rel_tid_i]=0, leave the bitmap and count unchanged and set err_o on that edge.
REQ-023 SHALL treat a release of the TID being granted in the same cycle as REQ-022 (error); the grant SHALL still complete.
REQ-024 SHALL update outstanding_o by +1 on a grant only, -1 on a legal release only, and 0 when both occur in the same cycle.
REQ-025 SHALL keep outstanding_o equal to the popcount of the bitmap at all times, within the range 0..NUM_TID.
REQ-026 SHALL drive full_o = (outstanding_o == NUM_TID) and idle_o = (outstanding_o == 0), both from registered state.
REQ-027 SHALL clear err_o on err_clr_i; if a new error and err_clr_i occur in the same cycle, set SHALL take priority.
REQ-028 SHALL allow full to non-full in one cycle via release; a grant SHALL NOT occur in the cycle the release is applied (per REQ-021).
REQ-029 SHALL, while drain_i=1, hold alloc_gnt_o=0 regardless of alloc_req_i and continue processing releases.

Reset
REQ-030 SHALL, while rst_ni=0, asynchronously clear the bitmap, outstanding_o=0, err_o=0, full_o=0 and idle_o=1.
REQ-031 SHALL, on reset mid-operation, discard all outstanding TIDs; the first grant after reset is TID 0.
REQ-032 SHALL hold alloc_gnt_o=0 during reset because full and drain do not gate the request path then; alloc_gnt_o SHALL follow REQ-017 from the first edge after deassertion.

Verification
REQ-033 SHALL cover the following case: after reset, alloc_req_i=1 for 3 cycles -> TIDs 0,1,2 granted; outstanding_o=3; idle_o=0.
REQ-034 SHALL cover the following case: allocate all 16 (width 4) -> full_o=1 and alloc_gnt_o=0 on the 17th request; release TID 5 -> next cycle grant returns 5 and full_o=1 again.
REQ-035 SHALL cover the following case: with TIDs 0..3 busy, release TID 1 and request in the same cycle -> grant TID 4; outstanding_o stays 4; the next request gets TID 1.
REQ-036 SHALL cover the following case: release TID 9 while it is free -> err_o=1 next cycle with count unchanged; then err_clr_i=1 -> err_o=0.
REQ-037 SHALL cover the following case: drain_i=1 with alloc_req_i=1 and 2 outstanding -> no grant; after both are released idle_o=1; then drain_i=0 -> grant TID 0.
REQ-038 SHALL cover the following case: assert rst_ni=0 asynchronously with 7 outstanding -> outputs reach reset values immediately; after release of reset the first grant is TID 0.
